// File: rtl/axis_h2c_byte_unpacker.sv
// Unpacks tkeep-qualified H2C AXI-Stream beats into a registered 1-byte/cycle stream,
// with beat/byte counters and a sticky flag for empty terminating beats.
module axis_h2c_byte_unpacker #(
    parameter int DATA_WIDTH  = 64,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                    AXI_clock,
    input  logic                    AXI_reset,
    input  logic [DATA_WIDTH-1:0]   AXIS_H2C_tdata,
    input  logic [DATA_WIDTH/8-1:0] AXIS_H2C_tkeep,
    input  logic                    AXIS_H2C_tlast,
    input  logic                    AXIS_H2C_tvalid,
    output logic                    AXIS_H2C_tready,
    output logic [7:0]              byte_data,
    output logic                    byte_valid,
    input  logic                    byte_ready,
    output logic                    byte_last,
    input  logic                    count_clear,
    output logic [COUNT_WIDTH-1:0]  byte_count,
    output logic [COUNT_WIDTH-1:0]  beat_count,
    output logic                    empty_last
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_WIDTH  = (KEEP_WIDTH > 1) ? $clog2(KEEP_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] data_r, data_s;
    logic [KEEP_WIDTH-1:0] rem_r, rem_s, low_s, rem_after_s;
    logic                  last_r, last_s;
    logic                  pop_s, accept_s, ready_s, single_s, empty_set_s;
    logic [IDX_WIDTH-1:0]  idx_s;

    // Next holding-buffer contents and the lowest lane to present next cycle
    always_comb begin
        pop_s       = byte_valid & byte_ready;
        low_s       = rem_r & (~rem_r + KEEP_WIDTH'(1));
        rem_after_s = pop_s ? (rem_r & ~low_s) : rem_r;
        // rem_r tracks lanes not yet handshaked, including the one on byte_data
        ready_s     = ~AXI_reset & ((rem_r == {KEEP_WIDTH{1'b0}}) |
                                    (pop_s & (rem_after_s == {KEEP_WIDTH{1'b0}})));
        accept_s    = AXIS_H2C_tvalid & ready_s;
        empty_set_s = accept_s & AXIS_H2C_tlast & (AXIS_H2C_tkeep == {KEEP_WIDTH{1'b0}});
        if (accept_s) begin
            data_s = AXIS_H2C_tdata;
            rem_s  = AXIS_H2C_tkeep;
            last_s = AXIS_H2C_tlast;
        end else begin
            data_s = data_r;
            rem_s  = rem_after_s;
            last_s = last_r;
        end
        single_s = (rem_s != {KEEP_WIDTH{1'b0}}) &&
                   ((rem_s & (rem_s - KEEP_WIDTH'(1))) == {KEEP_WIDTH{1'b0}});
        idx_s = {IDX_WIDTH{1'b0}};
        for (int i = KEEP_WIDTH - 1; i >= 0; i--) begin
            if (rem_s[i]) begin
                idx_s = IDX_WIDTH'(i);
            end else begin
                idx_s = idx_s;
            end
        end
    end

    assign AXIS_H2C_tready = ready_s;

    // Holding buffer and registered byte output
    always_ff @(posedge AXI_clock or posedge AXI_reset) begin
        if (AXI_reset) begin
            data_r     <= {DATA_WIDTH{1'b0}};
            rem_r      <= {KEEP_WIDTH{1'b0}};
            last_r     <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            byte_last  <= 1'b0;
        end else begin
            data_r     <= data_s;
            rem_r      <= rem_s;
            last_r     <= last_s;
            byte_valid <= (rem_s != {KEEP_WIDTH{1'b0}});
            byte_data  <= data_s[{idx_s, 3'b000} +: 8];
            byte_last  <= last_s & single_s;
        end
    end

    // Status counters; an increment in the clear cycle lands on the cleared value
    always_ff @(posedge AXI_clock or posedge AXI_reset) begin
        if (AXI_reset) begin
            byte_count <= {COUNT_WIDTH{1'b0}};
            beat_count <= {COUNT_WIDTH{1'b0}};
            empty_last <= 1'b0;
        end else begin
            byte_count <= (count_clear ? {COUNT_WIDTH{1'b0}} : byte_count) + COUNT_WIDTH'(pop_s);
            beat_count <= (count_clear ? {COUNT_WIDTH{1'b0}} : beat_count) + COUNT_WIDTH'(accept_s);
            empty_last <= (count_clear ? 1'b0 : empty_last) | empty_set_s;
        end
    end
endmodule

// File: tb/tb_axis_h2c_byte_unpacker.sv
// Bench for axis_h2c_byte_unpacker: byte-queue reference model checked every cycle,
// a table of single-packet vectors, directed corner sequences and randomized traffic.
module tb_axis_h2c_byte_unpacker;
    localparam int KW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] tdata = 64'h0;
    logic [7:0]  tkeep = 8'h00;
    logic        tlast = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready = 1'b1;
    logic        byte_last;
    logic        count_clear = 1'b0;
    logic [31:0] byte_count;
    logic [31:0] beat_count;
    logic        empty_last;

    axis_h2c_byte_unpacker #(.DATA_WIDTH(64), .COUNT_WIDTH(32)) dut (
        .AXI_clock(clk), .AXI_reset(rst),
        .AXIS_H2C_tdata(tdata), .AXIS_H2C_tkeep(tkeep), .AXIS_H2C_tlast(tlast),
        .AXIS_H2C_tvalid(tvalid), .AXIS_H2C_tready(tready),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .byte_last(byte_last), .count_clear(count_clear),
        .byte_count(byte_count), .beat_count(beat_count), .empty_last(empty_last)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] b; logic l; } mb_t;
    typedef struct {
        logic [63:0] data; logic [7:0] keep; logic last;
        int n; logic [7:0] first; logic [7:0] final_b; logic final_l;
    } vec_t;

    mb_t         mq[$];
    logic [31:0] m_bytes = 32'd0;
    logic [31:0] m_beats = 32'd0;
    logic        m_empty = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          br_mode = 0;
    int          rec_n = 0;
    int          gap = 0;
    logic [7:0]  rec_first, rec_final;
    logic        rec_final_l;
    logic        last_acc;
    vec_t        vec[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: compare DUT against the model, then advance the model at the edge
    task automatic cycle();
        logic ev, pop, er, acc;
        int   hi;
        mb_t  f, e;
        #1;
        ev  = (mq.size() != 0);
        pop = ev && byte_ready;
        er  = !ev || (pop && mq.size() == 1);
        acc = tvalid && er;
        chk("tready", {63'd0, tready}, {63'd0, er});
        chk("byte_valid", {63'd0, byte_valid}, {63'd0, ev});
        if (ev) begin
            f = mq[0];
            chk("byte_data", {56'd0, byte_data}, {56'd0, f.b});
            chk("byte_last", {63'd0, byte_last}, {63'd0, f.l});
        end
        chk("byte_count", {32'd0, byte_count}, {32'd0, m_bytes});
        chk("beat_count", {32'd0, beat_count}, {32'd0, m_beats});
        chk("empty_last", {63'd0, empty_last}, {63'd0, m_empty});
        if (rec_n > 0 && rec_n < 16 && !byte_valid) gap++;
        if (pop) begin
            if (rec_n == 0) rec_first = f.b;
            rec_final   = f.b;
            rec_final_l = f.l;
            rec_n++;
        end
        last_acc = acc;
        @(posedge clk);
        if (count_clear) begin
            m_bytes = 32'd0; m_beats = 32'd0; m_empty = 1'b0;
        end
        if (pop) begin
            void'(mq.pop_front());
            m_bytes++;
        end
        if (acc) begin
            m_beats++;
            hi = -1;
            for (int k = 0; k < KW; k++) if (tkeep[k]) hi = k;
            for (int k = 0; k < KW; k++) begin
                if (tkeep[k]) begin
                    e.b = tdata[8*k +: 8];
                    e.l = tlast && (k == hi);
                    mq.push_back(e);
                end
            end
            if (tkeep == 8'h00 && tlast) m_empty = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic tick();
        case (br_mode)
            0:       byte_ready = 1'b1;
            1:       byte_ready = ~byte_ready;
            default: byte_ready = 1'($urandom_range(0, 1));
        endcase
        cycle();
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n;
        tvalid = 1'b1; tdata = d; tkeep = k; tlast = l;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 200);
        if (!last_acc) chk("accept_timeout", 64'd0, 64'd1);
        tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (mq.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (mq.size() != 0) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic clear_counts();
        count_clear = 1'b1;
        tick();
        count_clear = 1'b0;
        rec_n = 0;
        gap = 0;
    endtask

    initial begin
        vec[0] = '{64'h0807060504030201, 8'hFF, 1'b1, 8, 8'h01, 8'h08, 1'b1};
        vec[1] = '{64'h1122334455667788, 8'hA5, 1'b1, 4, 8'h88, 8'h11, 1'b1};
        vec[2] = '{64'hDEADBEEFCAFEF00D, 8'h10, 1'b1, 1, 8'hEF, 8'hEF, 1'b1};
        vec[3] = '{64'h0123456789ABCDEF, 8'h81, 1'b0, 2, 8'hEF, 8'h01, 1'b0};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_tready", {63'd0, tready}, 64'd0);
        chk("rst_valid", {63'd0, byte_valid}, 64'd0);
        chk("rst_data", {56'd0, byte_data}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table of single-packet vectors, byte_ready held high
        for (int v = 0; v < 4; v++) begin
            clear_counts();
            send_beat(vec[v].data, vec[v].keep, vec[v].last);
            drain();
            chk("vec_nbytes", 64'(rec_n), 64'(vec[v].n));
            chk("vec_first", {56'd0, rec_first}, {56'd0, vec[v].first});
            chk("vec_final", {56'd0, rec_final}, {56'd0, vec[v].final_b});
            chk("vec_final_last", {63'd0, rec_final_l}, {63'd0, vec[v].final_l});
            chk("vec_byte_count", {32'd0, byte_count}, 64'(vec[v].n));
            chk("vec_beat_count", {32'd0, beat_count}, 64'd1);
        end

        // Two back-to-back full beats: byte_valid must not drop in between
        clear_counts();
        send_beat(64'h0807060504030201, 8'hFF, 1'b0);
        send_beat(64'h100F0E0D0C0B0A09, 8'hFF, 1'b1);
        drain();
        chk("b2b_nbytes", 64'(rec_n), 64'd16);
        chk("b2b_gap", 64'(gap), 64'd0);
        chk("b2b_final", {56'd0, rec_final}, 64'h10);

        // byte_ready toggling across a full beat
        clear_counts();
        br_mode = 1;
        byte_ready = 1'b1;
        send_beat(64'h2827262524232221, 8'hFF, 1'b1);
        drain();
        br_mode = 0;
        chk("toggle_nbytes", 64'(rec_n), 64'd8);
        chk("toggle_first", {56'd0, rec_first}, 64'h21);
        chk("toggle_final", {56'd0, rec_final}, 64'h28);

        // Empty terminating beat, clear, and clear coincident with a handshake
        clear_counts();
        send_beat(64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b1);
        tick();
        chk("empty_beats", {32'd0, beat_count}, 64'd1);
        chk("empty_flag", {63'd0, empty_last}, 64'd1);
        chk("empty_bytes", {32'd0, byte_count}, 64'd0);
        clear_counts();
        chk("clr_beats", {32'd0, beat_count}, 64'd0);
        chk("clr_flag", {63'd0, empty_last}, 64'd0);
        chk("clr_bytes", {32'd0, byte_count}, 64'd0);
        send_beat(64'h3837363534333231, 8'hFF, 1'b1);
        count_clear = 1'b1;
        tick();
        count_clear = 1'b0;
        chk("clr_hs_bytes", {32'd0, byte_count}, 64'd1);
        chk("clr_hs_beats", {32'd0, beat_count}, 64'd0);
        drain();

        // Asynchronous reset after three of eight bytes
        clear_counts();
        send_beat(64'h0807060504030201, 8'hFF, 1'b1);
        repeat (3) tick();
        chk("mid_taken", 64'(rec_n), 64'd3);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {63'd0, byte_valid}, 64'd0);
        chk("arst_data", {56'd0, byte_data}, 64'd0);
        chk("arst_last", {63'd0, byte_last}, 64'd0);
        chk("arst_tready", {63'd0, tready}, 64'd0);
        chk("arst_bytes", {32'd0, byte_count}, 64'd0);
        mq.delete();
        m_bytes = 32'd0; m_beats = 32'd0; m_empty = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rec_n = 0;
        send_beat(64'h1817161514131211, 8'hFF, 1'b1);
        drain();
        chk("post_first", {56'd0, rec_first}, 64'h11);
        chk("post_nbytes", 64'(rec_n), 64'd8);
        chk("post_bytes", {32'd0, byte_count}, 64'd8);
        chk("post_beats", {32'd0, beat_count}, 64'd1);

        // Randomized traffic against the model
        br_mode = 2;
        for (int it = 0; it < 200; it++) begin
            logic [7:0] k;
            count_clear = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) begin
                tick();
            end else begin
                case ($urandom_range(0, 9))
                    0:       k = 8'h00;
                    1:       k = 8'hFF;
                    default: k = 8'($urandom);
                endcase
                send_beat({$urandom, $urandom}, k, 1'($urandom_range(0, 1)));
            end
        end
        count_clear = 1'b0;
        drain();
        br_mode = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
